// File: rtl/sram_block_controller.sv
// sram_block_controller: maps a 68k bus cycle onto one of NUM_BLK SRAM blocks, inserts wait states, returns Dtack.
// Define SRAM_WRITE_PROTECT_EN to add a per-block write-protect mask that answers protected writes with BErr.
module sram_block_controller #(
   parameter int ADDR_W      = 17,
   parameter int BLK_LOG2    = 2,
   parameter int WAIT_STATES = 1,
   localparam int NUM_BLK    = 2**BLK_LOG2
) (
   input  logic               Clock,
   input  logic               Reset_L,
   input  logic [ADDR_W-1:0]  Address,
   input  logic               SRamSelect_H,
   input  logic               AS_L,
   input  logic               RW,
   input  logic               UDS_L,
   input  logic               LDS_L,
   output logic [NUM_BLK-1:0] BlockSel_H,
   output logic               SRamOE_L,
   output logic               SRamWE_L,
   output logic               SRamUB_L,
   output logic               SRamLB_L,
   output logic               Dtack_L,
   output logic               BErr_L,
   input  logic               WpLoad_H,
   input  logic [NUM_BLK-1:0] WpData
);

   typedef enum logic [2:0] {IDLE, SEL, WAIT, ACK, HOLD} state_t;

   state_t              state, state_next;
   logic [3:0]          wait_cnt, wait_cnt_next;
   logic [BLK_LOG2-1:0] addr_blk;
   logic [BLK_LOG2-1:0] blk_idx;
   logic                rw_lat;
   logic                wp_hit;
   logic                wp_hit_now;
   logic                start;
   logic                active;
   logic                ack_phase;
   logic                unused_ok;

   assign addr_blk = Address[ADDR_W-1 -: BLK_LOG2];
   assign start    = (state == IDLE) && !AS_L && SRamSelect_H;

`ifdef SRAM_WRITE_PROTECT_EN
   logic [NUM_BLK-1:0] wp_mask;

   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         wp_mask <= '0;
      end else if (WpLoad_H) begin
         wp_mask <= WpData;
      end
   end

   assign wp_hit_now = !RW && wp_mask[addr_blk];
   assign unused_ok  = ^Address[ADDR_W-BLK_LOG2-1:0];
`else
   assign wp_hit_now = 1'b0;
   assign unused_ok  = ^{Address[ADDR_W-BLK_LOG2-1:0], WpLoad_H, WpData};
`endif

   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Block, direction and protection verdict are frozen for the whole bus cycle
   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         blk_idx <= '0;
         rw_lat  <= 1'b1;
         wp_hit  <= 1'b0;
      end else if (start) begin
         blk_idx <= addr_blk;
         rw_lat  <= RW;
         wp_hit  <= wp_hit_now;
      end
   end

   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      case (state)
         IDLE: begin
            if (start) state_next = SEL;
         end
         SEL: begin
            if (AS_L) begin
               state_next = IDLE;
            end else if (wp_hit || (WAIT_STATES == 0)) begin
               state_next = ACK;
            end else begin
               state_next    = WAIT;
               wait_cnt_next = 4'(WAIT_STATES - 1);
            end
         end
         WAIT: begin
            if (AS_L) begin
               state_next = IDLE;
            end else if (wait_cnt == 4'd0) begin
               state_next = ACK;
            end else begin
               wait_cnt_next = wait_cnt - 4'd1;
            end
         end
         ACK:     state_next = HOLD;
         HOLD: begin
            if (AS_L) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A protected write still selects the block but never strobes WE and answers with BErr instead of Dtack
   always_comb begin
      active     = (state != IDLE);
      ack_phase  = (state == ACK) || (state == HOLD);
      BlockSel_H = '0;
      SRamOE_L   = 1'b1;
      SRamWE_L   = 1'b1;
      SRamUB_L   = 1'b1;
      SRamLB_L   = 1'b1;
      Dtack_L    = 1'b1;
      BErr_L     = 1'b1;
      if (active) begin
         BlockSel_H[blk_idx] = 1'b1;
         SRamOE_L = !rw_lat;
         SRamWE_L = rw_lat || wp_hit;
         SRamUB_L = UDS_L;
         SRamLB_L = LDS_L;
         if (ack_phase) begin
            Dtack_L = wp_hit;
            BErr_L  = !wp_hit;
         end
      end
   end

endmodule

// File: tb/tb_sram_block_controller.sv
// tb_sram_block_controller: three controller variants (default, 8 blocks/no waits, 3 waits) checked each cycle
// against a bus-cycle reference model counting edges since the qualifying address strobe.
module tb_sram_block_controller;

   logic        Clock = 1'b0;
   logic        Reset_L;
   logic [16:0] addr_a;
   logic [17:0] addr_b;
   logic        SRamSelect_H, AS_L, RW, UDS_L, LDS_L, WpLoad_H;
   logic [3:0]  wp_data_a;
   logic [7:0]  wp_data_b;
   logic [3:0]  sel_a, sel_c;
   logic [7:0]  sel_b;
   logic [2:0]  oe_l, we_l, ub_l, lb_l, dtack_l, berr_l;

   int          cmp_count = 0;
   int          err_count = 0;

   int          ws_of [3] = '{1, 0, 3};
   bit          m_busy [3];
   int          m_n [3];
   int          m_blk [3];
   bit          m_rw [3];
   bit          m_wp [3];
   int          m_ack_at [3];
   logic [7:0]  m_mask [3];

   sram_block_controller dut_a (
      .Clock(Clock), .Reset_L(Reset_L), .Address(addr_a), .SRamSelect_H(SRamSelect_H), .AS_L(AS_L),
      .RW(RW), .UDS_L(UDS_L), .LDS_L(LDS_L), .BlockSel_H(sel_a), .SRamOE_L(oe_l[0]), .SRamWE_L(we_l[0]),
      .SRamUB_L(ub_l[0]), .SRamLB_L(lb_l[0]), .Dtack_L(dtack_l[0]), .BErr_L(berr_l[0]),
      .WpLoad_H(WpLoad_H), .WpData(wp_data_a));

   sram_block_controller #(.ADDR_W(18), .BLK_LOG2(3), .WAIT_STATES(0)) dut_b (
      .Clock(Clock), .Reset_L(Reset_L), .Address(addr_b), .SRamSelect_H(SRamSelect_H), .AS_L(AS_L),
      .RW(RW), .UDS_L(UDS_L), .LDS_L(LDS_L), .BlockSel_H(sel_b), .SRamOE_L(oe_l[1]), .SRamWE_L(we_l[1]),
      .SRamUB_L(ub_l[1]), .SRamLB_L(lb_l[1]), .Dtack_L(dtack_l[1]), .BErr_L(berr_l[1]),
      .WpLoad_H(WpLoad_H), .WpData(wp_data_b));

   sram_block_controller #(.WAIT_STATES(3)) dut_c (
      .Clock(Clock), .Reset_L(Reset_L), .Address(addr_a), .SRamSelect_H(SRamSelect_H), .AS_L(AS_L),
      .RW(RW), .UDS_L(UDS_L), .LDS_L(LDS_L), .BlockSel_H(sel_c), .SRamOE_L(oe_l[2]), .SRamWE_L(we_l[2]),
      .SRamUB_L(ub_l[2]), .SRamLB_L(lb_l[2]), .Dtack_L(dtack_l[2]), .BErr_L(berr_l[2]),
      .WpLoad_H(WpLoad_H), .WpData(wp_data_a));

   always #5 Clock = ~Clock;

   task automatic modelReset();
      for (int d = 0; d < 3; d++) begin
         m_busy[d] = 1'b0;
         m_n[d]    = 0;
         m_mask[d] = 8'h00;
      end
   endtask

   // Edge count since the qualifying strobe decides everything: acknowledge arrives at WAIT_STATES+2,
   // or at 2 for a protected write, and the acknowledge edge itself ignores AS_L
   task automatic modelEdge();
      for (int d = 0; d < 3; d++) begin
         if (!m_busy[d]) begin
            if (!AS_L && SRamSelect_H) begin
               m_busy[d]   = 1'b1;
               m_n[d]      = 1;
               m_rw[d]     = RW;
               m_blk[d]    = (d == 1) ? int'(addr_b[17:15]) : int'(addr_a[16:15]);
               m_wp[d]     = !RW && m_mask[d][m_blk[d]];
               m_ack_at[d] = m_wp[d] ? 2 : ws_of[d] + 2;
            end
         end else if (m_n[d] == m_ack_at[d]) begin
            m_n[d]++;
         end else if (AS_L) begin
            m_busy[d] = 1'b0;
         end else if (m_n[d] < m_ack_at[d]) begin
            m_n[d]++;
         end
      end
`ifdef SRAM_WRITE_PROTECT_EN
      if (WpLoad_H) begin
         m_mask[0] = {4'b0000, wp_data_a};
         m_mask[2] = {4'b0000, wp_data_a};
         m_mask[1] = wp_data_b;
      end
`endif
   endtask

   function automatic logic [13:0] expVec(int d);
      logic [7:0] sel;
      bit         ackp;
      sel = 8'h00;
      if (m_busy[d]) sel[m_blk[d]] = 1'b1;
      ackp = m_busy[d] && (m_n[d] >= m_ack_at[d]);
      return {sel, !(m_busy[d] && m_rw[d]), !(m_busy[d] && !m_rw[d] && !m_wp[d]),
              m_busy[d] ? UDS_L : 1'b1, m_busy[d] ? LDS_L : 1'b1,
              !(ackp && !m_wp[d]), !(ackp && m_wp[d])};
   endfunction

   task automatic checkOutput(input string tag);
      logic [13:0] obs, exp_v;
      for (int d = 0; d < 3; d++) begin
         case (d)
            0:       obs = {4'b0000, sel_a, oe_l[0], we_l[0], ub_l[0], lb_l[0], dtack_l[0], berr_l[0]};
            1:       obs = {sel_b, oe_l[1], we_l[1], ub_l[1], lb_l[1], dtack_l[1], berr_l[1]};
            default: obs = {4'b0000, sel_c, oe_l[2], we_l[2], ub_l[2], lb_l[2], dtack_l[2], berr_l[2]};
         endcase
         exp_v = expVec(d);
         cmp_count++;
         assert (obs === exp_v) else begin
            err_count++;
            $error("[TB] FAIL %s dut%0d sel/oe/we/ub/lb/dtack/berr: observed %b expected %b", tag, d, obs, exp_v);
         end
      end
   endtask

   task automatic tick(input string tag);
      modelEdge();
      @(posedge Clock);
      #1;
      checkOutput(tag);
   endtask

   task automatic pulseReset(input string tag);
      #2 Reset_L = 1'b0;
      #1;
      modelReset();
      checkOutput({tag, "_async_rst"});
      #1 Reset_L = 1'b1;
   endtask

   // One bus cycle: AS_L low for low_cycles edges, then high for gap edges
   task automatic applyStimulus(input logic [16:0] a, input logic [17:0] b, input logic rw,
                                input logic uds, input logic lds, input logic hit, input int low_cycles,
                                input int gap, input int drop_sel_at, input int reset_at, input string tag);
      addr_a       = a;
      addr_b       = b;
      RW           = rw;
      UDS_L        = uds;
      LDS_L        = lds;
      SRamSelect_H = hit;
      AS_L         = 1'b0;
      for (int i = 0; i < low_cycles; i++) begin
         if (i == drop_sel_at) SRamSelect_H = 1'b0;
         if (i == reset_at) pulseReset(tag);
         tick(tag);
         WpLoad_H = 1'b0;
      end
      AS_L = 1'b1;
      for (int i = 0; i < gap; i++) begin
         tick({tag, "_gap"});
         SRamSelect_H = 1'b0;
      end
   endtask

   initial begin
      Reset_L      = 1'b0;
      addr_a       = '0;
      addr_b       = '0;
      SRamSelect_H = 1'b0;
      AS_L         = 1'b1;
      RW           = 1'b1;
      UDS_L        = 1'b1;
      LDS_L        = 1'b1;
      WpLoad_H     = 1'b0;
      wp_data_a    = '0;
      wp_data_b    = '0;
      #3;
      modelReset();
      checkOutput("reset");
      tick("reset_held");
      Reset_L = 1'b1;

      $display("[TB] directed bus cycles");
      applyStimulus(17'h0_8000, 18'h0_0000, 1'b1, 1'b0, 1'b0, 1'b1, 6, 2, -1, -1, "read_blk1");
      applyStimulus(17'h1_8000, 18'h2_C000, 1'b0, 1'b0, 1'b1, 1'b1, 6, 2, -1, -1, "write_upper");
      applyStimulus(17'h0_0000, 18'h1_0000, 1'b1, 1'b1, 1'b0, 1'b1, 3, 2, -1, -1, "abort_wait");
      applyStimulus(17'h1_0000, 18'h1_0000, 1'b1, 1'b0, 1'b0, 1'b1, 5, 1, 1, -1, "sel_drop");
      applyStimulus(17'h0_C000, 18'h3_8000, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1, -1, -1, "no_hit");
      applyStimulus(17'h0_8000, 18'h0_8000, 1'b1, 1'b0, 1'b0, 1'b1, 6, 1, -1, 3, "rst_in_ack");
      applyStimulus(17'h0_0000, 18'h0_0000, 1'b1, 1'b0, 1'b0, 1'b1, 6, 2, -1, -1, "read_blk0");
      applyStimulus(17'h0_4000, 18'h0_4000, 1'b1, 1'b0, 1'b0, 1'b1, 6, 1, -1, -1, "b2b_first");
      applyStimulus(17'h1_4000, 18'h1_4000, 1'b0, 1'b0, 1'b0, 1'b1, 6, 1, -1, -1, "b2b_second");

`ifdef SRAM_WRITE_PROTECT_EN
      wp_data_a = 4'b0100;
      wp_data_b = 8'b0000_0100;
      WpLoad_H  = 1'b1;
      tick("wp_load");
      WpLoad_H  = 1'b0;
      applyStimulus(17'h1_0000, 18'h1_0000, 1'b0, 1'b0, 1'b0, 1'b1, 6, 2, -1, -1, "wp_write");
      applyStimulus(17'h1_0000, 18'h1_0000, 1'b1, 1'b0, 1'b0, 1'b1, 6, 2, -1, -1, "wp_read");
`endif

      $display("[TB] randomized bus cycles");
      for (int t = 0; t < 150; t++) begin
         int low;
         int gap;
         int drop;
         int rst;
         low       = int'($urandom_range(1, 8));
         gap       = int'($urandom_range(1, 3));
         drop      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, low)) : -1;
         rst       = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, low - 1)) : -1;
         WpLoad_H  = ($urandom_range(0, 9) == 0);
         wp_data_a = 4'($urandom);
         wp_data_b = 8'($urandom);
         applyStimulus(17'($urandom), 18'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 7) != 0), low, gap, drop, rst, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
